cond_check_unit: RTL and testbench

//  Parametrised successor of the single-channel condition evaluator.

---
 rtl/cond_check_unit.sv | 108 ++++++++++
 tb/tb_cond_check_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cond_check_unit.sv
// NZCV flag register plus per-lane ARM-style condition evaluation with registered exec enables.
// Also keeps saturating pass/fail counters for performance debug.
module cond_check_unit #(
  parameter int          LANES     = 2,
  parameter bit          BYPASS    = 1'b1,
  parameter logic [3:0]  RST_FLAGS = 4'b0000,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flag_we,
  input  logic [3:0]           flag_in,
  input  logic [LANES-1:0]     in_valid,
  input  logic [4*LANES-1:0]   cond,
  input  logic                 cnt_clr,
  output logic [LANES-1:0]     out_valid,
  output logic [LANES-1:0]     exec,
  output logic [3:0]           flags,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [3:0]       eff;
  logic [LANES-1:0] pass_vec;
  logic [LANES-1:0] exec_next;
  logic [CNT_W:0]   p_add;
  logic [CNT_W:0]   f_add;
  logic [CNT_W:0]   pass_sum;
  logic [CNT_W:0]   fail_sum;
  logic [CNT_W-1:0] pass_next;
  logic [CNT_W-1:0] fail_next;

  // f = {N,Z,C,V}; code 1111 is "never" in this block rather than the legacy always
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic res;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = cy;
      4'b0011: res = !cy;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = cy & !z;
      4'b1001: res = !cy | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    eff       = (BYPASS && flag_we) ? flag_in : flags;
    pass_vec  = '0;
    exec_next = '0;
    p_add     = '0;
    f_add     = '0;
    for (int i = 0; i < LANES; i++) begin
      pass_vec[i]  = cond_pass(cond[4*i +: 4], eff);
      exec_next[i] = in_valid[i] & pass_vec[i];
      if (in_valid[i]) begin
        if (pass_vec[i]) p_add = p_add + (CNT_W+1)'(1);
        else             f_add = f_add + (CNT_W+1)'(1);
      end
    end
    // One extra bit of headroom so the wrap can be detected before clamping
    pass_sum  = {1'b0, pass_cnt} + p_add;
    fail_sum  = {1'b0, fail_cnt} + f_add;
    pass_next = (pass_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
    fail_next = (fail_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : fail_sum[CNT_W-1:0];
  end

  // A stalled cycle freezes everything, including any flag write presented during it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags     <= RST_FLAGS;
      out_valid <= '0;
      exec      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      exec      <= exec_next;
      if (flag_we) flags <= flag_in;
      if (cnt_clr) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else begin
        pass_cnt <= pass_next;
        fail_cnt <= fail_next;
      end
    end
  end

endmodule

// File: tb/tb_cond_check_unit.sv
// Scoreboard bench for cond_check_unit: a bypassing and a non-bypassing instance share stimulus.
// Directed vectors carry hand-computed results; a monitor pops them as registered outputs appear.
module tb_cond_check_unit;

  localparam int         LANES = 2;
  localparam int         CNT_W = 4;
  localparam logic [3:0] RSTF  = 4'b0010;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flag_we;
  logic [3:0]       flag_in;
  logic [LANES-1:0] in_valid;
  logic [4*LANES-1:0] cond;
  logic             cnt_clr;

  logic [LANES-1:0] ov_b, exec_b, ov_n, exec_n;
  logic [3:0]       flags_b, flags_n;
  logic [CNT_W-1:0] pc_b, fc_b, pc_n, fc_n;

  typedef struct {
    logic [1:0] ov;
    logic [1:0] eb;
    logic [1:0] en;
    logic [3:0] fl;
    logic [3:0] pc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  cond_check_unit #(.LANES(LANES), .BYPASS(1'b1), .RST_FLAGS(RSTF), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .flag_in(flag_in),
    .in_valid(in_valid), .cond(cond), .cnt_clr(cnt_clr),
    .out_valid(ov_b), .exec(exec_b), .flags(flags_b), .pass_cnt(pc_b), .fail_cnt(fc_b)
  );

  cond_check_unit #(.LANES(LANES), .BYPASS(1'b0), .RST_FLAGS(RSTF), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .flag_in(flag_in),
    .in_valid(in_valid), .cond(cond), .cnt_clr(cnt_clr),
    .out_valid(ov_n), .exec(exec_n), .flags(flags_n), .pass_cnt(pc_n), .fail_cnt(fc_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ov, input logic [1:0] eb,
                           input logic [1:0] en, input logic [3:0] fl,
                           input logic [3:0] pc, input logic [3:0] fc);
    check_output({tag, ".ov_b"},    32'(ov_b),    32'(ov));
    check_output({tag, ".ov_n"},    32'(ov_n),    32'(ov));
    check_output({tag, ".exec_b"},  32'(exec_b),  32'(eb));
    check_output({tag, ".exec_n"},  32'(exec_n),  32'(en));
    check_output({tag, ".flags_b"}, 32'(flags_b), 32'(fl));
    check_output({tag, ".flags_n"}, 32'(flags_n), 32'(fl));
    check_output({tag, ".pass_b"},  32'(pc_b),    32'(pc));
    check_output({tag, ".fail_b"},  32'(fc_b),    32'(fc));
    check_output({tag, ".pass_n"},  32'(pc_n),    32'(pc));
    check_output({tag, ".fail_n"},  32'(fc_n),    32'(fc));
  endtask

  // Drive one unstalled cycle at the falling edge; queue its expected registered result
  task automatic apply_stimulus(input logic we, input logic [3:0] fin, input logic [1:0] v,
                                input logic [7:0] c, input logic clr,
                                input logic [1:0] eb, input logic [1:0] en,
                                input logic [3:0] fl, input logic [3:0] pc, input logic [3:0] fc);
    exp_t e;
    @(negedge clk);
    stall    = 1'b0;
    flag_we  = we;
    flag_in  = fin;
    in_valid = v;
    cond     = c;
    cnt_clr  = clr;
    if (v != 2'b00) begin
      e.ov = v; e.eb = eb; e.en = en; e.fl = fl; e.pc = pc; e.fc = fc;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: after each edge that actually updated the outputs, compare any presented result
  always @(posedge clk) begin
    logic upd;
    exp_t e;
    upd = !stall && !rst;
    #1;
    if (upd && (ov_b != 2'b00 || ov_n != 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_output: got out_valid %0h expected none", ov_b);
      end else begin
        e = exp_q.pop_front();
        check_all("sb", e.ov, e.eb, e.en, e.fl, e.pc, e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    flag_we  = 1'b0;
    flag_in  = 4'b0000;
    in_valid = 2'b00;
    cond     = 8'h00;
    cnt_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 2'b00, 2'b00, 2'b00, RSTF, 4'd0, 4'd0);
    rst = 1'b0;

    // flags -> Z=1, then EQ/NE split across lanes
    apply_stimulus(1'b1, 4'b0100, 2'b00, 8'h00, 1'b0, 2'b00, 2'b00, 4'b0000, 4'd0, 4'd0);
    apply_stimulus(1'b0, 4'b0000, 2'b11, {4'b0001, 4'b0000}, 1'b0, 2'b01, 2'b01, 4'b0100, 4'd1, 4'd1);
    // bypass: same-cycle write of Z=1 seen only by the bypassing instance
    apply_stimulus(1'b1, 4'b0000, 2'b00, 8'h00, 1'b0, 2'b00, 2'b00, 4'b0000, 4'd0, 4'd0);
    apply_stimulus(1'b1, 4'b0100, 2'b11, {4'b0001, 4'b0000}, 1'b0, 2'b01, 2'b10, 4'b0100, 4'd2, 4'd2);
    // AL on invalid lane0, NV on valid lane1
    apply_stimulus(1'b0, 4'b0000, 2'b10, {4'b1111, 4'b1110}, 1'b0, 2'b00, 2'b00, 4'b0100, 4'd2, 4'd3);
    // GE / HI with a bypassed N=1,V=1 write
    apply_stimulus(1'b1, 4'b1001, 2'b11, {4'b1000, 4'b1010}, 1'b0, 2'b01, 2'b01, 4'b1001, 4'd3, 4'd4);
    apply_stimulus(1'b0, 4'b0000, 2'b11, {4'b0100, 4'b1011}, 1'b0, 2'b10, 2'b10, 4'b1001, 4'd4, 4'd5);
    apply_stimulus(1'b1, 4'b0010, 2'b11, {4'b1001, 4'b0010}, 1'b0, 2'b01, 2'b10, 4'b0010, 4'd5, 4'd6);

    // Stall with a pending flag write and clear: nothing may move
    @(negedge clk);
    stall    = 1'b1;
    flag_we  = 1'b1;
    flag_in  = 4'b1111;
    in_valid = 2'b11;
    cond     = {4'b0100, 4'b0000};
    cnt_clr  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_all("stall", 2'b11, 2'b01, 2'b10, 4'b0010, 4'd5, 4'd6);
    end

    // Lost write: EQ still evaluates against Z=0
    apply_stimulus(1'b0, 4'b0000, 2'b11, {4'b0010, 4'b0000}, 1'b0, 2'b10, 2'b10, 4'b0010, 4'd6, 4'd7);
    apply_stimulus(1'b0, 4'b0000, 2'b01, {4'b1101, 4'b1100}, 1'b0, 2'b01, 2'b01, 4'b0010, 4'd7, 4'd7);
    apply_stimulus(1'b0, 4'b0000, 2'b11, {4'b0101, 4'b0110}, 1'b0, 2'b10, 2'b10, 4'b0010, 4'd8, 4'd8);

    // Clear discards this cycle's counts, then climb to saturation at 15
    apply_stimulus(1'b0, 4'b0000, 2'b11, 8'hEE, 1'b1, 2'b11, 2'b11, 4'b0010, 4'd0, 4'd0);
    for (int k = 1; k <= 7; k++)
      apply_stimulus(1'b0, 4'b0000, 2'b11, 8'hEE, 1'b0, 2'b11, 2'b11, 4'b0010, 4'(2*k), 4'd0);
    apply_stimulus(1'b0, 4'b0000, 2'b11, 8'hEE, 1'b0, 2'b11, 2'b11, 4'b0010, 4'd15, 4'd0);
    apply_stimulus(1'b0, 4'b0000, 2'b11, 8'hEE, 1'b0, 2'b11, 2'b11, 4'b0010, 4'd15, 4'd0);
    apply_stimulus(1'b0, 4'b0000, 2'b11, 8'hEE, 1'b1, 2'b11, 2'b11, 4'b0010, 4'd0, 4'd0);
    apply_stimulus(1'b1, 4'b1111, 2'b01, {4'b1111, 4'b1110}, 1'b0, 2'b01, 2'b01, 4'b1111, 4'd1, 4'd0);

    // Asynchronous reset in mid-cycle with flags=1111 and a nonzero counter
    @(negedge clk);
    in_valid = 2'b00;
    flag_we  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 2'b00, 2'b00, 2'b00, RSTF, 4'd0, 4'd0);
    #1;
    rst = 1'b0;

    repeat (3) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
